// File: rtl/sign_blitter.sv
// -----------------------------------------------------------------------------
// sign_blitter
//
// Reader-side sequencer for 1-bit glyph/sign bitmap ROMs. A start pulse walks
// a SIGN_W x SIGN_H bitmap in row-major order. Each bit becomes a coloured
// pixel write at (org_x + col, org_y + row). The write goes to the LCD pixel
// sink over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        one-cycle draw request, honoured only when idle
//   org_x/org_y  top-left screen coordinate, latched on accepted start
//   fg_color     colour for bitmap bit 1, latched on accepted start
//   bg_color     colour for bitmap bit 0, latched on accepted start
//   transparent  1 = bit-0 pixels are skipped, latched on accepted start
//   rom_addr     registered ROM address (row*SIGN_W + col)
//   rom_data     combinational ROM bit for rom_addr
//   pix_valid    pixel write request
//   pix_ready    sink accept
//   pix_x/pix_y  pixel coordinate (wraps silently, no clipping)
//   pix_color    pixel colour
//   busy         high while the bitmap is being walked
//   done         one-cycle pulse after the final pixel is accepted or skipped
// -----------------------------------------------------------------------------
module sign_blitter #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SIGN_W      = 16,
  parameter int SIGN_H      = 8,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [X_WIDTH-1:0]     org_x,
  input  logic [Y_WIDTH-1:0]     org_y,
  input  logic [COLOR_WIDTH-1:0] fg_color,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  input  logic                   transparent,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic                   rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [X_WIDTH-1:0]     pix_x,
  output logic [Y_WIDTH-1:0]     pix_y,
  output logic [COLOR_WIDTH-1:0] pix_color,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (SIGN_W > 1) ? $clog2(SIGN_W) : 1;
  localparam int RW = (SIGN_H > 1) ? $clog2(SIGN_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(SIGN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SIGN_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          col_r, col_s;
  logic [RW-1:0]          row_r, row_s;
  logic [ADDR_WIDTH-1:0]  rom_addr_r, rom_addr_s;
  logic [X_WIDTH-1:0]     org_x_r, org_x_s;
  logic [Y_WIDTH-1:0]     org_y_r, org_y_s;
  logic [COLOR_WIDTH-1:0] fg_r, fg_s;
  logic [COLOR_WIDTH-1:0] bg_r, bg_s;
  logic                   transparent_r, transparent_s;
  logic                   pix_valid_r, pix_valid_s;
  logic [X_WIDTH-1:0]     pix_x_r, pix_x_s;
  logic [Y_WIDTH-1:0]     pix_y_r, pix_y_s;
  logic [COLOR_WIDTH-1:0] pix_color_r, pix_color_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic                   advance_s;
  logic                   last_s;

  // Next-state, counter advance and registered-output computation.
  always_comb begin
    state_s       = state_r;
    col_s         = col_r;
    row_s         = row_r;
    rom_addr_s    = rom_addr_r;
    org_x_s       = org_x_r;
    org_y_s       = org_y_r;
    fg_s          = fg_r;
    bg_s          = bg_r;
    transparent_s = transparent_r;
    pix_x_s       = pix_x_r;
    pix_y_s       = pix_y_r;
    pix_color_s   = pix_color_r;
    advance_s     = 1'b0;
    last_s        = (col_r == COL_LAST) && (row_r == ROW_LAST);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          org_x_s       = org_x;
          org_y_s       = org_y;
          fg_s          = fg_color;
          bg_s          = bg_color;
          transparent_s = transparent;
          col_s         = {CW{1'b0}};
          row_s         = {RW{1'b0}};
          rom_addr_s    = {ADDR_WIDTH{1'b0}};
          state_s       = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (transparent_r && !rom_data) begin
          // Skipped pixel: one cycle, no emission.
          advance_s = 1'b1;
          state_s   = last_s ? ST_DONE : ST_LOAD;
        end else begin
          pix_x_s     = org_x_r + X_WIDTH'(col_r);
          pix_y_s     = org_y_r + Y_WIDTH'(row_r);
          pix_color_s = rom_data ? fg_r : bg_r;
          state_s     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (pix_valid_r && pix_ready) begin
          advance_s = 1'b1;
          state_s   = last_s ? ST_DONE : ST_LOAD;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Row-major advance; the address tracks the counters and returns to 0
    // after the last pixel so it never drifts past the bitmap.
    if (advance_s) begin
      if (last_s) begin
        col_s      = {CW{1'b0}};
        row_s      = {RW{1'b0}};
        rom_addr_s = {ADDR_WIDTH{1'b0}};
      end else if (col_r == COL_LAST) begin
        col_s      = {CW{1'b0}};
        row_s      = row_r + RW'(1'b1);
        rom_addr_s = rom_addr_r + ADDR_WIDTH'(1'b1);
      end else begin
        col_s      = col_r + CW'(1'b1);
        rom_addr_s = rom_addr_r + ADDR_WIDTH'(1'b1);
      end
    end else begin
      col_s      = col_s;
      row_s      = row_s;
      rom_addr_s = rom_addr_s;
    end

    // Status outputs are decoded from the next state so they register cleanly.
    pix_valid_s = (state_s == ST_EMIT);
    busy_s      = (state_s == ST_LOAD) || (state_s == ST_EMIT);
    done_s      = (state_s == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      col_r         <= {CW{1'b0}};
      row_r         <= {RW{1'b0}};
      rom_addr_r    <= {ADDR_WIDTH{1'b0}};
      org_x_r       <= {X_WIDTH{1'b0}};
      org_y_r       <= {Y_WIDTH{1'b0}};
      fg_r          <= {COLOR_WIDTH{1'b0}};
      bg_r          <= {COLOR_WIDTH{1'b0}};
      transparent_r <= 1'b0;
      pix_valid_r   <= 1'b0;
      pix_x_r       <= {X_WIDTH{1'b0}};
      pix_y_r       <= {Y_WIDTH{1'b0}};
      pix_color_r   <= {COLOR_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      col_r         <= col_s;
      row_r         <= row_s;
      rom_addr_r    <= rom_addr_s;
      org_x_r       <= org_x_s;
      org_y_r       <= org_y_s;
      fg_r          <= fg_s;
      bg_r          <= bg_s;
      transparent_r <= transparent_s;
      pix_valid_r   <= pix_valid_s;
      pix_x_r       <= pix_x_s;
      pix_y_r       <= pix_y_s;
      pix_color_r   <= pix_color_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign pix_valid = pix_valid_r;
  assign pix_x     = pix_x_r;
  assign pix_y     = pix_y_r;
  assign pix_color = pix_color_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sign_blitter.sv
// -----------------------------------------------------------------------------
// tb_sign_blitter
//
// Self-checking bench for sign_blitter. A bitmap-level model produces the list
// of pixels a draw must emit. A negedge monitor pops that list on every
// handshake, checks that stalled pixels hold steady, and checks completion on
// done. Directed sequences pin timing, wrap and reset behaviour with literals.
// -----------------------------------------------------------------------------
module tb_sign_blitter;

  localparam int AW = 7;
  localparam int SW = 16;
  localparam int SH = 8;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CWD = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [XW-1:0]  org_x;
  logic [YW-1:0]  org_y;
  logic [CWD-1:0] fg_color;
  logic [CWD-1:0] bg_color;
  logic           transparent;
  logic [AW-1:0]  rom_addr;
  logic           rom_data;
  logic           pix_valid;
  logic           pix_ready;
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic [CWD-1:0] pix_color;
  logic           busy;
  logic           done;

  sign_blitter #(
    .ADDR_WIDTH(AW), .SIGN_W(SW), .SIGN_H(SH),
    .X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CWD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .org_x(org_x), .org_y(org_y), .fg_color(fg_color), .bg_color(bg_color),
    .transparent(transparent), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic rom_mem [0:SW*SH-1];
  assign rom_data = rom_mem[rom_addr];

  typedef struct packed {
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [CWD-1:0] c;
  } pix_t;

  pix_t           exp_q[$];
  int             errors = 0;
  int             checks = 0;
  int             acc_cnt = 0;
  int             done_cnt = 0;
  int             exp_total = 0;
  int             edge_cnt = 0;
  logic [XW-1:0]  acc_x [0:SW*SH-1];
  logic [YW-1:0]  acc_y [0:SW*SH-1];
  logic [CWD-1:0] acc_c [0:SW*SH-1];
  logic           mon_en = 1'b0;
  logic           rand_mode = 1'b0;
  logic           ready_fixed = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge counter used to pin cycle-exact timing.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Sink ready driver: fixed level or ~30% random.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_fixed;
    end
  end

  // Monitor: scoreboard compare on handshakes, stall stability, done check.
  initial begin : monitor
    logic held;
    pix_t held_pix;
    pix_t p;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (pix_valid && held) begin
          chk("hold_x", 32'(pix_x), 32'(held_pix.x));
          chk("hold_y", 32'(pix_y), 32'(held_pix.y));
          chk("hold_color", 32'(pix_color), 32'(held_pix.c));
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
          end else begin
            p = exp_q.pop_front();
            chk("pix_x", 32'(pix_x), 32'(p.x));
            chk("pix_y", 32'(pix_y), 32'(p.y));
            chk("pix_color", 32'(pix_color), 32'(p.c));
          end
          if (acc_cnt < SW*SH) begin
            acc_x[acc_cnt] = pix_x;
            acc_y[acc_cnt] = pix_y;
            acc_c[acc_cnt] = pix_color;
          end
          acc_cnt++;
        end
        held = pix_valid && !pix_ready;
        held_pix = {pix_x, pix_y, pix_color};
        if (done) begin
          done_cnt++;
          chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
          chk("done_pixel_count", 32'(acc_cnt), 32'(exp_total));
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Build the expected pixel list straight from the bitmap and draw settings.
  task automatic build_model(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                             input logic [CWD-1:0] fg, input logic [CWD-1:0] bg,
                             input logic tr);
    pix_t p;
    exp_q.delete();
    exp_total = 0;
    acc_cnt = 0;
    done_cnt = 0;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        if (tr && !rom_mem[r*SW + c]) continue;
        p.x = XW'((int'(ox) + c) % (1 << XW));
        p.y = YW'((int'(oy) + r) % (1 << YW));
        p.c = rom_mem[r*SW + c] ? fg : bg;
        exp_q.push_back(p);
        exp_total++;
      end
    end
  endtask

  // Set up the model and pulse start; e0 is the edge that samples start.
  task automatic launch(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                        input logic [CWD-1:0] fg, input logic [CWD-1:0] bg,
                        input logic tr, output int e0);
    build_model(ox, oy, fg, bg, tr);
    @(posedge clk);
    #1;
    org_x = ox; org_y = oy; fg_color = fg; bg_color = bg; transparent = tr;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int e_done);
    bit found;
    found = 1'b0;
    e_done = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        e_done = edge_cnt;
        chk("busy_low_at_done", 32'(busy), 32'd0);
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (acc_cnt >= n) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL acc_timeout: got %0d pixels expected %0d", acc_cnt, n);
    end
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int e0;
  int ed;

  initial begin
    rst_n = 1'b0; start = 1'b0; org_x = '0; org_y = '0;
    fg_color = '0; bg_color = '0; transparent = 1'b0;
    for (int a = 0; a < SW*SH; a++) rom_mem[a] = 1'b1;

    // 1: reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix_xyc", {7'd0, pix_x, pix_y, pix_color}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 2: all-ones bitmap, continuous ready
    launch(9'd10, 8'd20, 16'hF800, 16'h001F, 1'b0, e0);
    @(negedge clk);
    chk("t2_busy_after_start", 32'(busy), 32'd1);
    chk("t2_valid_edge0", 32'(pix_valid), 32'd0);
    chk("t2_rom_addr_start", 32'(rom_addr), 32'd0);
    @(negedge clk);
    chk("t2_valid_edge1", 32'(pix_valid), 32'd1);
    chk("t2_first_xyc", {7'd0, pix_x, pix_y, pix_color}, {7'd0, 9'd10, 8'd20, 16'hF800});
    wait_done(600, ed);
    chk("t2_done_edge", 32'(ed - e0), 32'd256);
    chk("t2_count", 32'(acc_cnt), 32'd128);
    chk("t2_last_xy", {15'd0, acc_x[127], acc_y[127]}, {15'd0, 9'd25, 8'd27});
    chk("t2_last_color", 32'(acc_c[127]), 32'hF800);

    // 3: checkerboard, transparent then opaque
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) rom_mem[r*SW + c] = ((r ^ c) & 1) != 0;
    launch(9'd30, 8'd40, 16'h07E0, 16'h001F, 1'b1, e0);
    wait_done(600, ed);
    chk("t3_transp_count", 32'(acc_cnt), 32'd64);
    chk("t3_transp_first", {15'd0, acc_x[0], acc_y[0]}, {15'd0, 9'd31, 8'd40});
    chk("t3_transp_color", 32'(acc_c[0]), 32'h07E0);
    launch(9'd30, 8'd40, 16'h07E0, 16'h001F, 1'b0, e0);
    wait_done(600, ed);
    chk("t3_opaque_count", 32'(acc_cnt), 32'd128);
    chk("t3_opaque_c0", 32'(acc_c[0]), 32'h001F);
    chk("t3_opaque_c1", 32'(acc_c[1]), 32'h07E0);
    chk("t3_opaque_c16", 32'(acc_c[16]), 32'h07E0);

    // 4: random ready with a scrambled bitmap
    for (int a = 0; a < SW*SH; a++) rom_mem[a] = (((a * 37) >> 3) & 1) != 0;
    rand_mode = 1'b1;
    launch(9'd200, 8'd100, 16'hABCD, 16'h1234, 1'b0, e0);
    wait_done(4000, ed);
    chk("t4_count", 32'(acc_cnt), 32'd128);
    rand_mode = 1'b0;

    // 5: coordinate wrap
    for (int a = 0; a < SW*SH; a++) rom_mem[a] = 1'b1;
    launch(9'd510, 8'd255, 16'hFFFF, 16'h0000, 1'b0, e0);
    wait_done(600, ed);
    chk("t5_x0", 32'(acc_x[0]), 32'd510);
    chk("t5_x1", 32'(acc_x[1]), 32'd511);
    chk("t5_x2_wrap", 32'(acc_x[2]), 32'd0);
    chk("t5_y_row1_wrap", 32'(acc_y[16]), 32'd0);

    // 6a: start while busy is ignored
    launch(9'd100, 8'd50, 16'h5555, 16'hAAAA, 1'b0, e0);
    wait_acc(40, 400);
    @(posedge clk);
    #1;
    start = 1'b1; org_x = 9'd200; org_y = 8'd9; fg_color = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(600, ed);
    chk("t6_count", 32'(acc_cnt), 32'd128);

    // 6b: reset mid-draw drops the draw with no done
    launch(9'd60, 8'd70, 16'h1111, 16'h2222, 1'b0, e0);
    wait_acc(60, 400);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(pix_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_addr", 32'(rom_addr), 32'd0);
    chk("t6_rst_xyc", {7'd0, pix_x, pix_y, pix_color}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t6_no_done_after_rst", 32'(done_cnt), 32'd0);
    launch(9'd5, 8'd6, 16'h3333, 16'h4444, 1'b0, e0);
    @(negedge clk);
    chk("t6_restart_addr", 32'(rom_addr), 32'd0);
    wait_done(600, ed);
    chk("t6_restart_count", 32'(acc_cnt), 32'd128);
    chk("t6_restart_first", {15'd0, acc_x[0], acc_y[0]}, {15'd0, 9'd5, 8'd6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
